// File: rtl/level_display_pkg.sv
// level_display_pkg: shared widths, 7-segment glyphs and thermometer-code check
// for the reservoir level indicator.
package level_display_pkg;
    localparam int SEG_W    = 7;
    localparam int LEVEL_W  = 4;
    localparam int MAX_SENS = 9;
    localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
    typedef struct packed {
        logic               valid;
        logic [LEVEL_W-1:0] count;
    } thermo_t;
    // Valid when the set bits form a contiguous run starting at bit 0.
    function automatic thermo_t is_thermo(input logic [MAX_SENS-1:0] v);
        thermo_t r;
        r.count = '0;
        for (int i = 0; i < MAX_SENS; i++) r.count += LEVEL_W'(v[i]);
        r.valid = (v == MAX_SENS'((10'd1 << r.count) - 10'd1));
        return r;
    endfunction
endpackage

// File: rtl/probe_debounce.sv
// probe_debounce: 2-flop synchroniser plus stable-count debounce for one probe bit.
module probe_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic probe_i,
    output logic deb_o
);
    localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    logic          s1_q, s2_q, deb_q, deb_d, diff, hit;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        diff  = s2_q ^ deb_q;
        hit   = diff && cnt_q == CW'(DEB_CYCLES - 1);
        deb_d = hit ? s2_q : deb_q;
        cnt_d = (!diff || hit) ? '0 : cnt_q + CW'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= probe_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end
    assign deb_o = deb_q;
endmodule

// File: rtl/level_display_ctrl.sv
// level_display_ctrl: debounced probe thermometer to level count and 7-segment digit,
// blinking 'E' on sensor fault. Define LEVEL_FAULT_LATCH_EN for a sticky fault cleared by fault_clr.
module level_display_ctrl
    import level_display_pkg::*;
#(
    parameter int N_SENS       = 3,
    parameter int DEB_CYCLES   = 16,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SENS-1:0]  probe,
    input  logic               fault_clr,
    output logic [SEG_W-1:0]   seg,
    output logic [LEVEL_W-1:0] level,
    output logic               fault,
    output logic               low_alarm
);
    localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
    logic [N_SENS-1:0]   deb;
    logic [MAX_SENS-1:0] deb_ext;
    thermo_t             th;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic                fault_q, fault_d, phase_q, phase_d, wrap, rise;
    logic [BW-1:0]       blink_q, blink_d;
    for (genvar g = 0; g < N_SENS; g++) begin : g_probe
        probe_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .probe_i(probe[g]),
            .deb_o  (deb[g])
        );
    end
`ifndef LEVEL_FAULT_LATCH_EN
    logic unused_clr;
    assign unused_clr = fault_clr;
`endif
    always_comb begin
        deb_ext             = '0;
        deb_ext[N_SENS-1:0] = deb;
        th                  = is_thermo(deb_ext);
`ifdef LEVEL_FAULT_LATCH_EN
        fault_d = !th.valid || (fault_q && !fault_clr);
`else
        fault_d = !th.valid;
`endif
        level_d = fault_d ? level_q : th.count;
        wrap    = blink_q == BW'(BLINK_CYCLES - 1);
        rise    = fault_d && !fault_q;
        // restart the blink on a new fault so its first cycle shows the glyph
        blink_d = (rise || wrap) ? '0 : blink_q + BW'(1);
        phase_d = rise ? 1'b0 : phase_q ^ wrap;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            fault_q <= 1'b0;
            blink_q <= '0;
            phase_q <= 1'b0;
        end else begin
            level_q <= level_d;
            fault_q <= fault_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end
    assign level     = level_q;
    assign fault     = fault_q;
    assign low_alarm = level_q == '0 && !fault_q;
    assign seg       = !fault_q ? SEG_DIGIT[level_q] : phase_q ? SEG_OFF : SEG_E;
endmodule

// File: tb/tb_level_display_ctrl.sv
// tb_level_display_ctrl: directed plus randomized check against a behavioural level/fault model.
module tb_level_display_ctrl;
    localparam int N = 3, DEB = 4, BLINK = 8;
    logic       clk = 1'b0, rst = 1'b1, fault_clr = 1'b0;
    logic [2:0] probe = '0;
    logic [6:0] seg;
    logic [3:0] level;
    logic       fault, low_alarm;
    logic [8:0] probe9 = '0;
    logic [6:0] seg9;
    logic [3:0] level9;
    logic       fault9, low9;
    int n_cmp = 0, n_err = 0;
    logic [6:0] dig [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    level_display_ctrl #(.N_SENS(N), .DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK)) dut (
        .clk(clk), .rst(rst), .probe(probe), .fault_clr(fault_clr),
        .seg(seg), .level(level), .fault(fault), .low_alarm(low_alarm)
    );
    level_display_ctrl #(.N_SENS(9), .DEB_CYCLES(1), .BLINK_CYCLES(BLINK)) dut9 (
        .clk(clk), .rst(rst), .probe(probe9), .fault_clr(fault_clr),
        .seg(seg9), .level(level9), .fault(fault9), .low_alarm(low9)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: raw samples delayed two edges, a bit flips once the last DEB delayed
    // samples all disagree with it, outputs follow the debounced vector one edge later.
    logic [2:0] r1, r2, m_deb;
    logic [2:0] win [$];
    logic [3:0] m_level;
    logic       m_fault;
    int         m_age;
    initial begin
        r1 = 0; r2 = 0; m_deb = 0; m_level = 0; m_fault = 0; m_age = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                r1 = 0; r2 = 0; m_deb = 0; m_level = 0; m_fault = 0; m_age = 0;
                win.delete();
            end else begin
                int  d;
                bit  valid, nf, all;
                d     = int'(m_deb);
                valid = (d & (d + 1)) == 0;
`ifdef LEVEL_FAULT_LATCH_EN
                nf = !valid || (m_fault && !fault_clr);
`else
                nf = !valid;
`endif
                m_age = (nf && !m_fault) ? 0 : m_age + 1;
                if (!nf) m_level = 4'($countones(m_deb));
                m_fault = nf;
                win.push_back(r2);
                if (win.size() > DEB) void'(win.pop_front());
                if (win.size() == DEB)
                    for (int i = 0; i < N; i++) begin
                        all = 1;
                        foreach (win[k]) if (win[k][i] == m_deb[i]) all = 0;
                        if (all) m_deb[i] = ~m_deb[i];
                    end
                r2 = r1;
                r1 = probe;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [6:0] e_seg;
            e_seg = m_fault ? (((m_age / BLINK) % 2) == 0 ? 7'h79 : 7'h00) : dig[m_level];
            chk("model_level", 32'(level), 32'(m_level));
            chk("model_fault", 32'(fault), 32'(m_fault));
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_low", 32'(low_alarm), 32'(m_level == 0 && !m_fault));
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step(1);
        chk("rst_seg", 32'(seg), 32'h3F);
        chk("rst_level", 32'(level), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_low", 32'(low_alarm), 1);
        probe9 = 9'h1FF; step(4);
        chk("n9_level9", 32'(level9), 9);
        chk("n9_seg9", 32'(seg9), 32'h6F);
        probe9 = 9'h0FF; step(4);
        chk("n9_level8", 32'(level9), 8);
        chk("n9_seg8", 32'(seg9), 32'h7F);
        chk("n9_fault", 32'(fault9), 0);
        probe = 3'b011; step(6);
        chk("lat_early", 32'(level), 0);
        step(1);
        chk("lat_level2", 32'(level), 2);
        chk("lat_seg2", 32'(seg), 32'h5B);
        chk("lat_low", 32'(low_alarm), 0);
        probe = 3'b111; step(7);
        chk("lvl3", 32'(level), 3);
        chk("seg3", 32'(seg), 32'h4F);
        probe = 3'b011; step(10);
        probe = 3'b111; step(3);
        probe = 3'b011; step(10);
        chk("glitch3", 32'(level), 2);
        probe = 3'b111; step(4);
        probe = 3'b011; step(3);
        chk("glitch4", 32'(level), 3);
        step(10);
        probe = 3'b001; step(10);
        probe = 3'b101; step(7);
        chk("flt_on", 32'(fault), 1);
        chk("flt_seg", 32'(seg), 32'h79);
        chk("flt_level", 32'(level), 1);
        step(7);
        chk("blink_on", 32'(seg), 32'h79);
        step(1);
        chk("blink_off", 32'(seg), 32'h00);
        probe = 3'b001;
`ifdef LEVEL_FAULT_LATCH_EN
        step(10);
        chk("latch_hold", 32'(fault), 1);
        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        chk("latch_clr", 32'(fault), 0);
        chk("latch_seg", 32'(seg), 32'h06);
`else
        step(7);
        chk("flt_clr", 32'(fault), 0);
        chk("flt_clr_seg", 32'(seg), 32'h06);
`endif
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("arst_seg", 32'(seg), 32'h3F);
                chk("arst_level", 32'(level), 0);
                chk("arst_fault", 32'(fault), 0);
                chk("arst_low", 32'(low_alarm), 1);
                @(posedge clk);
                #2 rst = 1'b0;
                step(1);
            end
            probe = 3'($urandom_range(7));
            for (int c = $urandom_range(12, 1); c > 0; c--) begin
                fault_clr = $urandom_range(3) == 0;
                step(1);
            end
            fault_clr = 1'b0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
